// File: rtl/mfp_ahb_lite_eic_prio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mfp_ahb_lite_eic_prio_pkg
// Brief    : Shared constants and types for the priority EIC: register word
//            offsets, priority field width and arbiter index width.
// Revision : 1.0 - initial release
// ============================================================================
package mfp_ahb_lite_eic_prio_pkg;

  localparam int PRIO_WIDTH          = 6;
  localparam int EIC_PRIO_ADDR_WIDTH = 6;
  // Winner index width; covers the full 1..32 channel range.
  localparam int IDX_WIDTH           = 5;

  // Register word offsets (byte offset / 4).
  localparam logic [EIC_PRIO_ADDR_WIDTH-1:0] c_reg_ctrl      = 6'h00;
  localparam logic [EIC_PRIO_ADDR_WIDTH-1:0] c_reg_pend      = 6'h01;
  localparam logic [EIC_PRIO_ADDR_WIDTH-1:0] c_reg_sense     = 6'h02;
  localparam logic [EIC_PRIO_ADDR_WIDTH-1:0] c_reg_swset     = 6'h03;
  localparam logic [EIC_PRIO_ADDR_WIDTH-1:0] c_reg_prio_base = 6'h10;

  typedef logic [PRIO_WIDTH-1:0] prio_t;

endpackage
`default_nettype wire

// File: rtl/mfp_ahb_lite_eic_prio_if.sv
`default_nettype none
// ============================================================================
// Module   : mfp_ahb_lite_eic_prio_if
// Brief    : AHB-Lite slave port bundle for the priority EIC.
// Revision : 1.0 - initial release
// ============================================================================
interface mfp_ahb_lite_eic_prio_if;

  logic [31:0] HADDR;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HSEL, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HSEL, HTRANS, HWRITE, HSIZE, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface
`default_nettype wire

// File: rtl/mfp_ahb_lite_eic_prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mfp_ahb_lite_eic_prio_arbiter
// Brief    : Combinational priority select. Highest priority among the
//            requesting channels wins; equal priorities resolve to the
//            lowest channel index.
// Revision : 1.0 - initial release
// ============================================================================
module mfp_ahb_lite_eic_prio_arbiter
  import mfp_ahb_lite_eic_prio_pkg::*;
#(
  parameter int CHANNELS = 16
) (
  input  logic [CHANNELS-1:0]            req,
  input  logic [CHANNELS*PRIO_WIDTH-1:0] prio_flat,
  output logic                           valid,
  output logic [IDX_WIDTH-1:0]           win_idx,
  output prio_t                          win_prio
);

  // Scan from index 0 upward; a strictly-greater compare keeps the earlier
  // (lower-index) channel on a tie.
  always_comb begin
    valid    = 1'b0;
    win_idx  = '0;
    win_prio = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (req[n] && (prio_flat[n*PRIO_WIDTH +: PRIO_WIDTH] > win_prio)) begin
        valid    = 1'b1;
        win_idx  = IDX_WIDTH'(n);
        win_prio = prio_flat[n*PRIO_WIDTH +: PRIO_WIDTH];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mfp_ahb_lite_eic_prio.sv
`default_nettype none
// ============================================================================
// Module   : mfp_ahb_lite_eic_prio
// Brief    : Priority external interrupt controller for MIPSfpga+. AHB-Lite
//            register file, input synchronisers, edge/level pending logic
//            and registered EIC outputs for the core's SI_* interface.
// Revision : 1.0 - initial release
// ============================================================================
module mfp_ahb_lite_eic_prio
  import mfp_ahb_lite_eic_prio_pkg::*;
#(
  parameter int          CHANNELS    = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [16:0] OFFSET_BASE = 17'h0100,
  parameter logic [16:0] OFFSET_STEP = 17'h0010,
  parameter logic [3:0]  SHADOW_SET  = 4'h0
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  mfp_ahb_lite_eic_prio_if.slave        ahb,
  input  logic [CHANNELS-1:0]           EIC_input,
  output logic [16:0]                   EIC_Offset,
  output logic [3:0]                    EIC_ShadowSet,
  output logic [7:0]                    EIC_Interrupt,
  output logic [5:0]                    EIC_Vector,
  output logic                          EIC_Present,
  input  logic                          EIC_IAck,
  input  logic [7:0]                    EIC_IPL,
  input  logic [5:0]                    EIC_IVN,
  input  logic [16:0]                   EIC_ION
);

  localparam int PW = PRIO_WIDTH;

  // ---------------------------------------------------------------- AHB
  logic                           r_dp_valid;
  logic                           r_dp_write;
  logic [EIC_PRIO_ADDR_WIDTH-1:0] r_dp_addr;
  logic [31:0]                    r_hrdata;

  logic                           w_accept;
  logic [EIC_PRIO_ADDR_WIDTH-1:0] w_addr;
  logic                           w_wr;
  logic                           w_fwd;

  assign w_accept = ahb.HSEL & ahb.HTRANS[1];  // HREADY is always 1
  assign w_addr   = ahb.HADDR[7:2];
  assign w_wr     = r_dp_valid & r_dp_write;
  assign w_fwd    = w_wr & (r_dp_addr == w_addr);

  assign ahb.HRDATA = r_hrdata;
  assign ahb.HREADY = 1'b1;
  assign ahb.HRESP  = 1'b0;

  // Latch the address phase so the write lands with HWDATA one cycle later.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= '0;
    end else begin
      r_dp_valid <= w_accept;
      if (w_accept) begin
        r_dp_write <= ahb.HWRITE;
        r_dp_addr  <= w_addr;
      end
    end
  end

  // ---------------------------------------------------------- registers
  logic                       r_gen;
  logic [CHANNELS-1:0]        r_sense;
  logic [CHANNELS*PW-1:0]     r_prio;
  logic [CHANNELS-1:0]        r_pend;      // edge-channel pending
  logic [CHANNELS-1:0]        r_sw_latch;  // level-channel software request

  logic                       w_gen_nxt;
  logic [CHANNELS-1:0]        w_sense_nxt;
  logic [CHANNELS*PW-1:0]     w_prio_nxt;
  logic [CHANNELS-1:0]        w_pend_nxt;
  logic [CHANNELS-1:0]        w_latch_nxt;
  logic [CHANNELS-1:0]        w_wdata_ch;
  logic [CHANNELS-1:0]        w_w1c;
  logic [CHANNELS-1:0]        w_swset;
  logic [CHANNELS-1:0]        w_sense_chg;
  logic [CHANNELS-1:0]        w_prio_nz;
  logic [CHANNELS-1:0]        w_iack_hit;

  assign w_wdata_ch  = ahb.HWDATA[CHANNELS-1:0];
  assign w_gen_nxt   = (w_wr && r_dp_addr == c_reg_ctrl)  ? ahb.HWDATA[0] : r_gen;
  assign w_sense_nxt = (w_wr && r_dp_addr == c_reg_sense) ? w_wdata_ch    : r_sense;
  assign w_w1c       = (w_wr && r_dp_addr == c_reg_pend)  ? w_wdata_ch    : '0;
  assign w_swset     = (w_wr && r_dp_addr == c_reg_swset) ? w_wdata_ch    : '0;
  assign w_sense_chg = r_sense ^ w_sense_nxt;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_prio
    logic w_hit;
    assign w_hit = w_wr && (r_dp_addr == (c_reg_prio_base + EIC_PRIO_ADDR_WIDTH'(n)));
    assign w_prio_nxt[n*PW +: PW] = w_hit ? ahb.HWDATA[PW-1:0] : r_prio[n*PW +: PW];
    assign w_prio_nz[n] = |r_prio[n*PW +: PW];
  end

  // Decode the acknowledged vector; vector 0 and out-of-range vectors hit nothing.
  always_comb begin
    w_iack_hit = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      w_iack_hit[n] = EIC_IAck && (EIC_IVN == 6'(n + 1));
    end
  end

  // ------------------------------------------------------ input path
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
  logic [CHANNELS-1:0]                  r_prev;
  logic [CHANNELS-1:0]                  w_sync;
  logic [CHANNELS-1:0]                  w_edge;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_edge = w_sync & ~r_prev;

  // Synchroniser chain plus the previous-level flop of the edge detector.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], EIC_input};
      r_prev <= w_sync;
    end
  end

  // Set terms are OR'd after the clear mask so a simultaneous set wins;
  // a SENSE change wipes the channel's state regardless.
  assign w_pend_nxt  = r_sense & (w_edge | w_swset | (r_pend & ~(w_w1c | w_iack_hit)))
                       & ~w_sense_chg;
  assign w_latch_nxt = ~r_sense & (w_swset | (r_sw_latch & ~w_w1c)) & ~w_sense_chg;

  // Level channels follow the synchronised input directly, so dropping the
  // source removes the request one stage earlier than an edge would set it.
  logic [CHANNELS-1:0] w_pend_cur;
  logic [CHANNELS-1:0] w_pend_fwd;
  assign w_pend_cur = (r_sense & r_pend) | (~r_sense & (w_sync | r_sw_latch));
  assign w_pend_fwd = (w_sense_nxt & w_pend_nxt) | (~w_sense_nxt & (w_sync | w_latch_nxt));

  // Register file update.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_gen      <= 1'b0;
      r_sense    <= '0;
      r_prio     <= '0;
      r_pend     <= '0;
      r_sw_latch <= '0;
    end else begin
      r_gen      <= w_gen_nxt;
      r_sense    <= w_sense_nxt;
      r_prio     <= w_prio_nxt;
      r_pend     <= w_pend_nxt;
      r_sw_latch <= w_latch_nxt;
    end
  end

  // -------------------------------------------------------- read path
  function automatic logic [31:0] f_read(
    input logic [EIC_PRIO_ADDR_WIDTH-1:0] a,
    input logic                           gen,
    input logic [CHANNELS-1:0]            pend,
    input logic [CHANNELS-1:0]            sense,
    input logic [CHANNELS*PW-1:0]         prio
  );
    logic [31:0] d;
    d = '0;
    if (a == c_reg_ctrl) begin
      d[0] = gen;
    end else if (a == c_reg_pend) begin
      d[CHANNELS-1:0] = pend;
    end else if (a == c_reg_sense) begin
      d[CHANNELS-1:0] = sense;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (a == (c_reg_prio_base + EIC_PRIO_ADDR_WIDTH'(n))) begin
          d[PW-1:0] = prio[n*PW +: PW];
        end
      end
    end
    return d;
  endfunction

  // Read data is captured at the address-phase edge. The *_nxt values equal
  // the current ones unless the in-flight write targets them, which gives
  // write forwarding for free; PEND needs the explicit select because its
  // next value also carries hardware events.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_hrdata <= '0;
    end else if (w_accept && !ahb.HWRITE) begin
      r_hrdata <= f_read(w_addr, w_gen_nxt, w_fwd ? w_pend_fwd : w_pend_cur,
                         w_sense_nxt, w_prio_nxt);
    end
  end

  // ----------------------------------------------------------- arbiter
  logic                 w_valid;
  logic [IDX_WIDTH-1:0] w_win_idx;
  prio_t                w_win_prio;
  logic [CHANNELS-1:0]  w_req;
  logic [5:0]           w_vec_nxt;

  assign w_req = w_pend_cur & w_prio_nz & {CHANNELS{r_gen}};

  mfp_ahb_lite_eic_prio_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arbiter (
    .req       (w_req),
    .prio_flat (r_prio),
    .valid     (w_valid),
    .win_idx   (w_win_idx),
    .win_prio  (w_win_prio)
  );

  assign w_vec_nxt = w_valid ? ({1'b0, w_win_idx} + 6'd1) : 6'd0;

  logic [7:0]  r_int;
  logic [5:0]  r_vec;
  logic [16:0] r_offset;

  // Registered EIC request towards the core.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_int    <= 8'h00;
      r_vec    <= 6'd0;
      r_offset <= OFFSET_BASE;
    end else begin
      r_int    <= w_valid ? {2'b00, w_win_prio} : 8'h00;
      r_vec    <= w_vec_nxt;
      r_offset <= OFFSET_BASE + ({11'b0, w_vec_nxt} * OFFSET_STEP);
    end
  end

  assign EIC_Interrupt = r_int;
  assign EIC_Vector    = r_vec;
  assign EIC_Offset    = r_offset;
  assign EIC_ShadowSet = SHADOW_SET;
  assign EIC_Present   = 1'b1;

  // Inputs that carry no information for this controller.
  logic w_unused_bits;
  assign w_unused_bits = ^{ahb.HSIZE, ahb.HTRANS[0], ahb.HADDR[31:8], ahb.HADDR[1:0],
                           ahb.HWDATA, EIC_IPL, EIC_ION};

endmodule
`default_nettype wire

// File: tb/tb_mfp_ahb_lite_eic_prio.sv
`default_nettype none
// ============================================================================
// Module   : tb_mfp_ahb_lite_eic_prio
// Brief    : Directed self-checking bench for the priority EIC.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mfp_ahb_lite_eic_prio;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [15:0] EIC_input = '0;
  logic [16:0] EIC_Offset;
  logic [3:0]  EIC_ShadowSet;
  logic [7:0]  EIC_Interrupt;
  logic [5:0]  EIC_Vector;
  logic        EIC_Present;
  logic        EIC_IAck = 1'b0;
  logic [7:0]  EIC_IPL = '0;
  logic [5:0]  EIC_IVN = '0;
  logic [16:0] EIC_ION = '0;

  int n_checks = 0;
  int n_pass   = 0;

  mfp_ahb_lite_eic_prio_if ahb ();

  mfp_ahb_lite_eic_prio #(
    .CHANNELS    (16),
    .SYNC_STAGES (2),
    .OFFSET_BASE (17'h0100),
    .OFFSET_STEP (17'h0010),
    .SHADOW_SET  (4'h0)
  ) dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .ahb           (ahb),
    .EIC_input     (EIC_input),
    .EIC_Offset    (EIC_Offset),
    .EIC_ShadowSet (EIC_ShadowSet),
    .EIC_Interrupt (EIC_Interrupt),
    .EIC_Vector    (EIC_Vector),
    .EIC_Present   (EIC_Present),
    .EIC_IAck      (EIC_IAck),
    .EIC_IPL       (EIC_IPL),
    .EIC_IVN       (EIC_IVN),
    .EIC_ION       (EIC_ION)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    ahb.HSEL   = 1'b0;
    ahb.HTRANS = 2'b00;
    ahb.HWRITE = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1'b1; ahb.HADDR = addr;
    tick();
    bus_idle();
    ahb.HWDATA = data;
    tick();
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1'b0; ahb.HADDR = addr;
    tick();
    bus_idle();
    data = ahb.HRDATA;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] addrs [4];
    addrs = '{32'h00, 32'h04, 32'h08, 32'h40};
    foreach (addrs[i]) begin
      bus_read(addrs[i], rd);
      n_checks++;
      if (rd !== 32'h0) $display("FAIL reset_read[%0h]: got %h expected 00000000", addrs[i], rd);
      else n_pass++;
    end
    n_checks++;
    if (EIC_Interrupt !== 8'h00) $display("FAIL reset_int: got %h expected 00", EIC_Interrupt);
    else n_pass++;
    n_checks++;
    if (EIC_Vector !== 6'd0) $display("FAIL reset_vec: got %0d expected 0", EIC_Vector);
    else n_pass++;
    n_checks++;
    if (EIC_Offset !== 17'h0100) $display("FAIL reset_offset: got %h expected 00100", EIC_Offset);
    else n_pass++;
    n_checks++;
    if (ahb.HREADY !== 1'b1 || ahb.HRESP !== 1'b0)
      $display("FAIL reset_hready_hresp: got %b/%b expected 1/0", ahb.HREADY, ahb.HRESP);
    else n_pass++;
  endtask

  task automatic test_edge_iack();
    logic [31:0] rd;
    bus_write(32'h00, 32'h1);
    bus_write(32'h08, 32'h8);
    bus_write(32'h4C, 32'h5);
    EIC_input[3] = 1'b1;
    tick();
    EIC_input[3] = 1'b0;
    tick();
    tick();
    n_checks++;
    if (EIC_Interrupt !== 8'h00) $display("FAIL edge_early: got %h expected 00", EIC_Interrupt);
    else n_pass++;
    tick();
    n_checks++;
    if (EIC_Interrupt !== 8'h05 || EIC_Vector !== 6'd4)
      $display("FAIL edge_latency: got int %h vec %0d expected int 05 vec 4", EIC_Interrupt, EIC_Vector);
    else n_pass++;
    n_checks++;
    if (EIC_Offset !== 17'h0140) $display("FAIL edge_offset: got %h expected 00140", EIC_Offset);
    else n_pass++;
    bus_read(32'h04, rd);
    n_checks++;
    if (rd !== 32'h8) $display("FAIL edge_pend: got %h expected 00000008", rd);
    else n_pass++;
    // Acks for vector 0 and an out-of-range vector must be ignored.
    EIC_IAck = 1'b1; EIC_IVN = 6'd0;
    tick();
    EIC_IVN = 6'd17;
    tick();
    EIC_IAck = 1'b0;
    tick();
    n_checks++;
    if (EIC_Interrupt !== 8'h05) $display("FAIL iack_ignored: got %h expected 05", EIC_Interrupt);
    else n_pass++;
    EIC_IAck = 1'b1; EIC_IVN = 6'd4;
    tick();
    EIC_IAck = 1'b0;
    tick();
    n_checks++;
    if (EIC_Interrupt !== 8'h00 || EIC_Vector !== 6'd0 || EIC_Offset !== 17'h0100)
      $display("FAIL iack_retire: got int %h vec %0d off %h expected 00/0/00100",
               EIC_Interrupt, EIC_Vector, EIC_Offset);
    else n_pass++;
    bus_read(32'h04, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL iack_pend: got %h expected 00000000", rd);
    else n_pass++;
  endtask

  task automatic test_tie_break();
    bus_write(32'h08, 32'h4A);
    bus_write(32'h44, 32'h7);
    bus_write(32'h58, 32'h7);
    bus_write(32'h0C, 32'h42);
    tick();
    n_checks++;
    if (EIC_Vector !== 6'd2 || EIC_Interrupt !== 8'h07)
      $display("FAIL tie_low_index: got vec %0d int %h expected vec 2 int 07", EIC_Vector, EIC_Interrupt);
    else n_pass++;
    bus_write(32'h58, 32'h9);
    n_checks++;
    if (EIC_Vector !== 6'd2) $display("FAIL prio_update_early: got vec %0d expected 2", EIC_Vector);
    else n_pass++;
    tick();
    n_checks++;
    if (EIC_Vector !== 6'd7 || EIC_Interrupt !== 8'h09 || EIC_Offset !== 17'h0170)
      $display("FAIL prio_update: got vec %0d int %h off %h expected 7/09/00170",
               EIC_Vector, EIC_Interrupt, EIC_Offset);
    else n_pass++;
    bus_write(32'h04, 32'h42);
    tick();
    n_checks++;
    if (EIC_Interrupt !== 8'h00) $display("FAIL w1c_idle: got %h expected 00", EIC_Interrupt);
    else n_pass++;
  endtask

  task automatic test_level();
    logic [31:0] rd;
    bus_write(32'h48, 32'h3);
    EIC_input[2] = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (EIC_Interrupt !== 8'h03 || EIC_Vector !== 6'd3)
      $display("FAIL level_req: got int %h vec %0d expected 03/3", EIC_Interrupt, EIC_Vector);
    else n_pass++;
    EIC_IAck = 1'b1; EIC_IVN = 6'd3;
    tick();
    EIC_IAck = 1'b0;
    tick();
    bus_read(32'h04, rd);
    n_checks++;
    if (rd !== 32'h4) $display("FAIL level_iack_pend: got %h expected 00000004", rd);
    else n_pass++;
    n_checks++;
    if (EIC_Interrupt !== 8'h03) $display("FAIL level_iack_int: got %h expected 03", EIC_Interrupt);
    else n_pass++;
    EIC_input[2] = 1'b0;
    tick();
    tick();
    n_checks++;
    if (EIC_Interrupt !== 8'h03) $display("FAIL level_drop_early: got %h expected 03", EIC_Interrupt);
    else n_pass++;
    tick();
    n_checks++;
    if (EIC_Interrupt !== 8'h00) $display("FAIL level_drop: got %h expected 00", EIC_Interrupt);
    else n_pass++;
  endtask

  task automatic test_set_beats_clear();
    logic [31:0] rd;
    bus_write(32'h08, 32'h4B);
    bus_write(32'h0C, 32'h1);
    bus_read(32'h04, rd);
    n_checks++;
    if (rd !== 32'h1) $display("FAIL swset_pend: got %h expected 00000001", rd);
    else n_pass++;
    EIC_input[0] = 1'b1;
    tick();
    tick();
    EIC_IAck = 1'b1; EIC_IVN = 6'd1;
    tick();
    EIC_IAck = 1'b0;
    EIC_input[0] = 1'b0;
    bus_read(32'h04, rd);
    n_checks++;
    if (rd !== 32'h1) $display("FAIL set_beats_clear: got %h expected 00000001", rd);
    else n_pass++;
    bus_write(32'h04, 32'h1);
    bus_read(32'h04, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL w1c_pend: got %h expected 00000000", rd);
    else n_pass++;
    // Toggling SENSE away and back must not resurrect the old pending bit.
    bus_write(32'h0C, 32'h1);
    bus_write(32'h08, 32'h4A);
    bus_write(32'h08, 32'h4B);
    bus_read(32'h04, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL sense_change_clear: got %h expected 00000000", rd);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1'b1; ahb.HADDR = 32'h54;
    tick();
    ahb.HWDATA = 32'hFFFF_FFEA;
    ahb.HWRITE = 1'b0;
    tick();
    bus_idle();
    rd = ahb.HRDATA;
    n_checks++;
    if (rd !== 32'h2A) $display("FAIL raw_forward: got %h expected 0000002a", rd);
    else n_pass++;
    bus_read(32'h54, rd);
    n_checks++;
    if (rd !== 32'h2A) $display("FAIL prio_readback: got %h expected 0000002a", rd);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    bus_write(32'h0C, 32'h8);
    tick();
    n_checks++;
    if (EIC_Interrupt !== 8'h05) $display("FAIL pre_reset_int: got %h expected 05", EIC_Interrupt);
    else n_pass++;
    #3;
    HRESET = 1'b1;
    #1;
    n_checks++;
    if (EIC_Interrupt !== 8'h00 || EIC_Vector !== 6'd0 || EIC_Offset !== 17'h0100 || ahb.HRDATA !== 32'h0)
      $display("FAIL async_reset: got int %h vec %0d off %h rd %h expected 00/0/00100/0",
               EIC_Interrupt, EIC_Vector, EIC_Offset, ahb.HRDATA);
    else n_pass++;
    #2;
    HRESET = 1'b0;
    tick();
    bus_read(32'h4C, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL reset_prio3: got %h expected 00000000", rd);
    else n_pass++;
    bus_read(32'h54, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL reset_prio5: got %h expected 00000000", rd);
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (EIC_Interrupt !== 8'h00 || EIC_Vector !== 6'd0)
      $display("FAIL post_reset_idle: got int %h vec %0d expected 00/0", EIC_Interrupt, EIC_Vector);
    else n_pass++;
  endtask

  initial begin
    ahb.HADDR  = '0;
    ahb.HSIZE  = 3'b010;
    ahb.HWDATA = '0;
    bus_idle();
    HRESET = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
    tick();
    test_reset();
    test_edge_iack();
    test_tie_break();
    test_level();
    test_set_beats_clear();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
